ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical samples needed to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles without a falling ps2_clk edge that abort a partial frame.
REQ-003 Port clk  input  1: system clock; the only clock domain.
REQ-004 Port rst  input  1: asynchronous, active-low reset; low resets all state.
REQ-005 Port ps2_clk  input  1: PS/2 clock from keyboard; asynchronous to clk.
REQ-006 Port ps2_data  input  1: PS/2 data from keyboard; asynchronous to clk.
REQ-007 Port key_code  output  8: scan code of the last completed key event.
REQ-008 Port key_extended  output  1: last event carried an E0 prefix.
REQ-009 Port key_release  output  1: last event carried an F0 (break) prefix.
REQ-010 Port key_valid  output  1: one-cycle pulse; key_code/key_extended/key_release are valid on this cycle and hold afterwards.
REQ-011 Port frame_err  output  1: one-cycle pulse on parity error, bad start/stop bit, or timeout.

Function
REQ-012 ps2_clk and ps2_data each pass through a 2-flop synchronizer before any use.
REQ-013 Filtered ps2_clk changes level only after FILTER_LEN consecutive equal synchronized samples; reset value is 1.
REQ-014 A bit is sampled from synchronized ps2_data on the cycle the filtered ps2_clk goes 1->0.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP; reset state is IDLE.
REQ-016 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> frame_err pulse, stay IDLE.
REQ-017 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: store the sampled bit -> STOP; parity is valid when data bits plus parity bit hold an odd count of ones.
REQ-019 STOP: sampled 1 and parity valid -> byte accepted; otherwise frame_err pulse; in either case -> IDLE.
REQ-020 Byte accepted and byte = 0xE0: set pending-extended flag; no key_valid.
REQ-021 Byte accepted and byte = 0xF0: set pending-release flag; no key_valid.
REQ-022 Any other accepted byte, one cycle later: key_code = byte, key_extended/key_release = pending flags, key_valid pulses, both pending flags clear.
REQ-023 Timeout counter clears on every falling edge and while in IDLE.
REQ-024 Timeout counter reaching TIMEOUT_CYC outside IDLE: -> IDLE, frame_err pulse, pending flags clear.
REQ-025 frame_err never clears pending flags except on timeout; key_valid and frame_err are never asserted on the same cycle.
REQ-026 Sequence E0 F0 xx yields exactly one key_valid with both key_extended and key_release set.

Reset
REQ-027 While rst = 0: FSM IDLE; shift register, bit count, timeout counter, pending flags, key_code, key_extended, key_release = 0; key_valid = frame_err = 0; filtered ps2_clk = 1.
REQ-028 rst asserted mid-frame discards the partial frame; the first falling edge after release is treated as a start bit.

Structure
REQ-029 A shared package holds the FSM state enum, the prefix constants 0xE0 and 0xF0, and the default FILTER_LEN and TIMEOUT_CYC.
REQ-030 The synchronizer plus glitch filter is one sub-module, ps2_line_filter, instantiated for ps2_clk; ps2_data uses the synchronizer only.

Verification
REQ-031 Frame 0x1C (A), odd parity 0, stop 1 -> one key_valid; key_code = 0x1C, extended = 0, release = 0.
REQ-032 Frames F0 then 1C -> exactly one key_valid; key_code = 0x1C, release = 1, extended = 0.
REQ-033 Frames E0, F0, 75 -> exactly one key_valid; key_code = 0x75, extended = 1, release = 1; next frame 0x1C reports both flags 0.
REQ-034 Frame 0x1C with parity forced to 1 -> frame_err pulse, no key_valid; a following good 0x1C frame -> key_valid.
REQ-035 Stop after 4 data bits with TIMEOUT_CYC = 200 -> frame_err pulse 200 cycles after the last edge; the next full 0x29 frame decodes correctly.
REQ-036 A 3-cycle low glitch on ps2_clk with FILTER_LEN = 8 -> no bit sampled; rst low mid-frame -> all outputs 0 and FSM IDLE.

Source files
------------

// File: rtl/ps2_key_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_receiver_pkg
// Brief    : Shared types and constants for the PS/2 keyboard receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_key_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] C_PREFIX_EXT      = 8'hE0;
  localparam logic [7:0] C_PREFIX_REL      = 8'hF0;
  localparam int         C_DEF_FILTER_LEN  = 8;
  localparam int         C_DEF_TIMEOUT_CYC = 100000;

  // Odd parity: data plus parity bit must carry an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Brief    : Two-flop synchronizer followed by a run-length glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  localparam int                C_CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(FILTER_LEN - 1);

  logic [1:0]         r_sync;
  logic [C_CNT_W-1:0] r_cnt;

  // The counter tracks how many consecutive samples disagree with the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= 2'b11;
      r_cnt    <= '0;
      line_out <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], line_in};
      if (r_sync[1] == line_out) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt    <= '0;
        line_out <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_receiver
// Brief    : PS/2 keyboard frame receiver with E0/F0 prefix decoding.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int FILTER_LEN  = C_DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = C_DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int                C_TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYC - 1);

  logic              w_filt_clk;
  logic              w_fall;
  logic              w_bit;
  logic [1:0]        r_data_sync;
  logic              r_filt_prev;
  frame_state_t      r_state;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_parity;
  logic [C_TO_W-1:0] r_to_cnt;
  logic              r_pend_ext;
  logic              r_pend_rel;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .rst      (rst),
    .line_in  (ps2_clk),
    .line_out (w_filt_clk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_sync <= 2'b11;
    end else begin
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  assign w_fall = r_filt_prev & ~w_filt_clk;
  assign w_bit  = r_data_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt_prev  <= 1'b1;
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_pend_ext   <= 1'b0;
      r_pend_rel   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_filt_prev <= w_filt_clk;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!w_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_parity <= w_bit;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (w_bit && parity_ok(r_shift, r_parity)) begin
              if (r_shift == C_PREFIX_EXT) begin
                r_pend_ext <= 1'b1;
              end else if (r_shift == C_PREFIX_REL) begin
                r_pend_rel <= 1'b1;
              end else begin
                key_code     <= r_shift;
                key_extended <= r_pend_ext;
                key_release  <= r_pend_rel;
                key_valid    <= 1'b1;
                r_pend_ext   <= 1'b0;
                r_pend_rel   <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == C_TO_LAST) begin
        // Stalled mid-frame: drop the frame and any half-built prefix sequence.
        r_to_cnt   <= '0;
        r_state    <= ST_IDLE;
        frame_err  <= 1'b1;
        r_pend_ext <= 1'b0;
        r_pend_rel <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_receiver
// Brief    : Directed self-checking bench for ps2_key_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_receiver;
  import ps2_key_receiver_pkg::*;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 200;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       key_valid;
  logic       frame_err;

  int checks;
  int errors;
  int kv_cnt;
  int fe_cnt;
  int both_cnt;
  int cyc;
  int last_low;

  ps2_key_receiver #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_release  (key_release),
    .key_valid    (key_valid),
    .frame_err    (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (key_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    kv_cnt   = 0;
    fe_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(15);
    ps2_clk  = 1'b0;
    last_low = cyc;
    wait_cyc(30);
    ps2_clk  = 1'b1;
    wait_cyc(15);
  endtask

  // Sends start + nbits data bits; a full frame adds parity and stop.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits);
    logic [7:0] v;
    v = b;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(v[i]);
    if (nbits == 8) begin
      send_bit((~^v) ^ par_flip);
      send_bit(1'b1);
    end
    ps2_data = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    checks++;
    if (key_code !== 8'h00 || key_extended !== 1'b0 || key_release !== 1'b0) begin
      errors++;
      $display("FAIL reset_key: got code=%h ext=%b rel=%b want 00 0 0", key_code, key_extended, key_release);
    end
    checks++;
    if (key_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got kv=%b fe=%b want 0 0", key_valid, frame_err);
    end
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_IDLE);
    end
    rst = 1'b1;
    wait_cyc(5);
    clear_counts();
  endtask

  task automatic test_make_code();
    clear_counts();
    send_frame(8'h1C, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || fe_cnt !== 0) begin
      errors++;
      $display("FAIL make_counts: got kv=%0d fe=%0d want 1 0", kv_cnt, fe_cnt);
    end
    checks++;
    if (key_code !== 8'h1C || key_extended !== 1'b0 || key_release !== 1'b0) begin
      errors++;
      $display("FAIL make_key: got code=%h ext=%b rel=%b want 1c 0 0", key_code, key_extended, key_release);
    end
  endtask

  task automatic test_break();
    clear_counts();
    send_frame(8'hF0, 1'b0, 8);
    checks++;
    if (kv_cnt !== 0) begin
      errors++;
      $display("FAIL break_prefix_kv: got %0d want 0", kv_cnt);
    end
    send_frame(8'h1C, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || fe_cnt !== 0) begin
      errors++;
      $display("FAIL break_counts: got kv=%0d fe=%0d want 1 0", kv_cnt, fe_cnt);
    end
    checks++;
    if (key_code !== 8'h1C || key_extended !== 1'b0 || key_release !== 1'b1) begin
      errors++;
      $display("FAIL break_key: got code=%h ext=%b rel=%b want 1c 0 1", key_code, key_extended, key_release);
    end
  endtask

  task automatic test_ext_break();
    clear_counts();
    send_frame(8'hE0, 1'b0, 8);
    send_frame(8'hF0, 1'b0, 8);
    send_frame(8'h75, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || fe_cnt !== 0) begin
      errors++;
      $display("FAIL ext_counts: got kv=%0d fe=%0d want 1 0", kv_cnt, fe_cnt);
    end
    checks++;
    if (key_code !== 8'h75 || key_extended !== 1'b1 || key_release !== 1'b1) begin
      errors++;
      $display("FAIL ext_key: got code=%h ext=%b rel=%b want 75 1 1", key_code, key_extended, key_release);
    end
    send_frame(8'h1C, 1'b0, 8);
    checks++;
    if (kv_cnt !== 2 || key_code !== 8'h1C || key_extended !== 1'b0 || key_release !== 1'b0) begin
      errors++;
      $display("FAIL ext_flags_clear: got kv=%0d code=%h ext=%b rel=%b want 2 1c 0 0",
               kv_cnt, key_code, key_extended, key_release);
    end
  endtask

  task automatic test_parity_err();
    clear_counts();
    send_frame(8'h1C, 1'b1, 8);
    checks++;
    if (fe_cnt !== 1 || kv_cnt !== 0) begin
      errors++;
      $display("FAIL parity_err: got fe=%0d kv=%0d want 1 0", fe_cnt, kv_cnt);
    end
    send_frame(8'h1C, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || key_code !== 8'h1C) begin
      errors++;
      $display("FAIL parity_recover: got kv=%0d code=%h want 1 1c", kv_cnt, key_code);
    end
  endtask

  task automatic test_timeout();
    int elapsed;
    logic seen;
    clear_counts();
    seen = 1'b0;
    send_frame(8'h0F, 1'b0, 4);
    for (int i = 0; i < 400 && !seen; i++) begin
      wait_cyc(1);
      if (frame_err) seen = 1'b1;
    end
    elapsed = cyc - last_low;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_seen: got no frame_err want pulse");
    end
    checks++;
    if (elapsed < TIMEOUT_CYC + 5 || elapsed > TIMEOUT_CYC + 20) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", elapsed, TIMEOUT_CYC + 5, TIMEOUT_CYC + 20);
    end
    wait_cyc(5);
    send_frame(8'h29, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || fe_cnt !== 1 || key_code !== 8'h29) begin
      errors++;
      $display("FAIL timeout_recover: got kv=%0d fe=%0d code=%h want 1 1 29", kv_cnt, fe_cnt, key_code);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    wait_cyc(30);
    checks++;
    if (fe_cnt !== 0 || kv_cnt !== 0) begin
      errors++;
      $display("FAIL glitch: got fe=%0d kv=%0d want 0 0", fe_cnt, kv_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_frame(8'h05, 1'b0, 3);
    checks++;
    if (dut.r_state !== ST_DATA) begin
      errors++;
      $display("FAIL midrst_pre_state: got %0d want %0d", dut.r_state, ST_DATA);
    end
    rst = 1'b0;
    wait_cyc(2);
    checks++;
    if (key_code !== 8'h00 || key_extended !== 1'b0 || key_release !== 1'b0 ||
        key_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got code=%h ext=%b rel=%b kv=%b fe=%b want all 0",
               key_code, key_extended, key_release, key_valid, frame_err);
    end
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midrst_state: got %0d want %0d", dut.r_state, ST_IDLE);
    end
    rst = 1'b1;
    wait_cyc(5);
    clear_counts();
    send_frame(8'h1C, 1'b0, 8);
    checks++;
    if (kv_cnt !== 1 || fe_cnt !== 0 || key_code !== 8'h1C) begin
      errors++;
      $display("FAIL midrst_recover: got kv=%0d fe=%0d code=%h want 1 0 1c", kv_cnt, fe_cnt, key_code);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL kv_fe_overlap: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_low = 0;
    clear_counts();
    test_reset();
    test_make_code();
    test_break();
    test_ext_break();
    test_parity_err();
    test_exclusive();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
